// File: rtl/uart_pkg.sv
// Shared definitions for the PicoBlaze serial transmit path: FSM states,
// default clocking constants and the baud divisor helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      PARITY
   } tx_state_t;

   localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;
   localparam int unsigned DEFAULT_BAUD   = 115_200;

   function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO queueing transmit bytes; a push while full is dropped
// and reported on 'dropped', even when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     pb_reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     push_ok,
   output logic                     dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign dropped = push & full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter behind PicoBlaze output port 03. Defining
// UART_TX_PARITY_EN inserts an even-parity bit, giving 8E1 frames.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = DEFAULT_CLK_HZ,
   parameter int BAUD       = DEFAULT_BAUD,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       pb_reset,
   input  logic [7:0] tx_data_in,
   input  logic       write_tx_data,
   output logic       tx_buffer_full,
   output logic       tx_busy,
   output logic       tx_overflow,
   output logic       rs232_tx
);

   localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);
   localparam int BW      = $clog2(DIVISOR);
   localparam int CW      = $clog2(FIFO_DEPTH) + 1;

   tx_state_t     state, state_next;
   logic [BW-1:0] baud_cnt, baud_next;
   logic [2:0]    bit_idx, bit_next;
   logic [7:0]    shift, shift_next;
   logic          tx_next;
   logic          busy_next;
   logic          pop;
   logic          bit_end;
   logic [CW-1:0] count_after;

   logic [7:0]    fifo_head;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          push_ok;
   logic          dropped;

`ifdef UART_TX_PARITY_EN
   logic          parity_bit, parity_next;
`endif

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .pb_reset  (pb_reset),
      .push      (write_tx_data),
      .push_data (tx_data_in),
      .pop       (pop),
      .head      (fifo_head),
      .full      (tx_buffer_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .push_ok   (push_ok),
      .dropped   (dropped)
   );

   assign bit_end     = (baud_cnt == BW'(DIVISOR - 1));
   assign count_after = fifo_count + CW'(push_ok) - CW'(pop);

   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         rs232_tx    <= 1'b1;
         tx_busy     <= 1'b0;
         tx_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit  <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         baud_cnt    <= baud_next;
         bit_idx     <= bit_next;
         shift       <= shift_next;
         rs232_tx    <= tx_next;
         tx_busy     <= busy_next;
         tx_overflow <= tx_overflow | dropped;
`ifdef UART_TX_PARITY_EN
         parity_bit  <= parity_next;
`endif
      end
   end

   // Line level and busy are derived from next-state values so the
   // registered outputs line up with the state they describe.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt + 1'b1;
      bit_next   = bit_idx;
      shift_next = shift;
      pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_bit;
`endif
      case (state)
         IDLE: begin
            baud_next = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_head;
               bit_next   = '0;
`ifdef UART_TX_PARITY_EN
               parity_next = ^fifo_head;
`endif
               state_next = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_next  = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_next  = '0;
               shift_next = shift >> 1;
               bit_next   = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               baud_next  = '0;
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               baud_next = '0;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_head;
                  bit_next   = '0;
`ifdef UART_TX_PARITY_EN
                  parity_next = ^fifo_head;
`endif
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase

      busy_next = (state_next != IDLE) | (count_after != '0);
   end

endmodule
